seg_mem_ctrl: RTL and testbench
===============================

Name: seg_mem_ctrl

Overview:
Parametrised segmented memory controller with a registered instruction-fetch port and a registered data port.
- Instruction port reads a dedicated instruction store.
- Data port is decoded into three contiguous data segments plus a memory-mapped IO window.
- Adds synchronous 1-cycle read latency with valid handshake, sticky address-fault capture, and a synchronised, edge-latched start input.

Parameters:
WIDTH, 32, data word width
IWIDTH, 24, instruction word width
IMEM_DEPTH, 1024, instruction store depth (words)
SEG0_SIZE, 32, data segment 0 size (words), base 0
SEG1_SIZE, 1024, data segment 1 size, base SEG0_SIZE
SEG2_SIZE, 750, data segment 2 size, base SEG0_SIZE+SEG1_SIZE
IO_BASE, 1806, first IO word address; must be >= SEG0_SIZE+SEG1_SIZE+SEG2_SIZE
NUM_IO, 2, IO registers (3 when IO_TIMER_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction read request
i_addr  in  WIDTH  instruction word address
i_rvalid  out  1  instruction data valid
i_rdata  out  IWIDTH  instruction word
i_fault  out  1  pulse: i_addr >= IMEM_DEPTH
d_req  in  1  data access request
d_we  in  1  1 = write, 0 = read (sampled with d_req)
d_addr  in  WIDTH  data word address (unsigned)
d_wdata  in  WIDTH  write data
d_rvalid  out  1  data read valid
d_rdata  out  WIDTH  read data
start_in  in  1  asynchronous start button/line
io_out  out  WIDTH  value of IO register 1
fault  out  1  sticky data-port fault flag
fault_addr  out  WIDTH  address of first faulting data access

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. Reset clears i_rvalid, i_rdata, i_fault, d_rvalid, d_rdata, io_out, fault, fault_addr, the start synchroniser, the start latch and the timer to 0. Memory array contents are not reset.
- Instruction port:
  - i_req at cycle N gives i_rvalid=1 with i_rdata at cycle N+1.
  - No i_req leaves i_rvalid=0 and i_rdata holding its last value.
  - Out-of-range address: i_rdata=0, i_rvalid=1 and i_fault=1 for that one cycle.
- Data decode, first match wins:
  - addr < S0 → seg0, offset addr
  - < S0+S1 → seg1, offset addr-S0
  - < S0+S1+S2 → seg2, offset addr-S0-S1
  - IO_BASE ≤ addr < IO_BASE+NUM_IO → IO, index addr-IO_BASE
  - otherwise → fault
- Data reads: d_req with d_we=0 at N gives d_rvalid=1 and d_rdata at N+1. A faulting read returns 0.
- Data writes: d_req with d_we=1 commits at the clock edge and produces no d_rvalid. A read of the same address issued the following cycle returns the new data.
- Single data access per cycle, so no read/write collision on the data port. The instruction and data stores are independent and have no contention.
- IO register 0 (status):
  - bit0 = start latch; upper bits read 0.
  - start_in passes through a 2-flop synchroniser, and a rising edge of the synchronised value sets the latch.
  - Writing with bit0=1 clears the latch.
  - If a set edge and a clearing write occur in the same cycle, the set wins.
- IO register 1: read/write scratch register driving io_out. Update is visible on io_out the cycle after the write.
- Fault capture:
  - Any faulting data access (read or write) sets fault. A faulting write is discarded.
  - fault_addr captures the address only when fault was 0 (first fault kept).
  - fault is cleared only by reset.

Optional Feature:
IO_TIMER_EN
- Defined: NUM_IO is effectively 3. IO register 2 is a free-running WIDTH-bit cycle counter, reset to 0, incrementing every clock and wrapping from all-ones to 0. Writing to it loads d_wdata, which takes effect the next cycle, after which counting continues from that value.
- Undefined: address IO_BASE+2 is outside the IO window and faults.

Test Plan:
1. Reset check: rst_n asserted mid-read (after d_req, before the edge) → d_rvalid=0, d_rdata=0, fault=0, io_out=0 immediately, asynchronously.
2. Segment boundaries: write 0xA5 to addr 31, 0xB6 to addr 32, 0xC7 to addr 1805, then read each back → values returned one cycle after the request. Read of addr 1806+NUM_IO → d_rdata=0, fault=1, fault_addr=1808.
3. Start latch: pulse start_in high for 3 cycles → read IO_BASE gives 1 starting 3 cycles after the edge. Write 1 to IO_BASE → next read gives 0. Edge coincident with the clearing write → latch stays 1.
4. Instruction port: i_req at addr 0 then addr 1023 then addr 1024 → i_rvalid each next cycle. The last returns i_rdata=0 with a one-cycle i_fault.
5. Write then read: write 0xDEADBEEF to addr 100, then read addr 100 the next cycle → 0xDEADBEEF. Write 0x5 to IO_BASE+1 → io_out=5 the following cycle.
6. IO_TIMER_EN: write 0xFFFFFFFE to IO_BASE+2, then read it twice on successive cycles → values 0xFFFFFFFF, then 0x00000000 (wrap). Without the macro, the same write sets fault.

Source files
------------

// File: rtl/seg_mem_ctrl.sv
// Segmented memory controller: registered instruction ROM port plus a data port decoded into
// three RAM segments and an IO window. Optional macro IO_TIMER_EN adds a free-running IO timer.
module seg_mem_ctrl #(
   parameter int WIDTH      = 32,
   parameter int IWIDTH     = 24,
   parameter int IMEM_DEPTH = 1024,
   parameter int SEG0_SIZE  = 32,
   parameter int SEG1_SIZE  = 1024,
   parameter int SEG2_SIZE  = 750,
   parameter int IO_BASE    = 1806,
   parameter int NUM_IO     = 2,
   parameter logic [IWIDTH*IMEM_DEPTH-1:0] IMEM_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [WIDTH-1:0]  i_addr,
   output logic              i_rvalid,
   output logic [IWIDTH-1:0] i_rdata,
   output logic              i_fault,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [WIDTH-1:0]  d_addr,
   input  logic [WIDTH-1:0]  d_wdata,
   output logic              d_rvalid,
   output logic [WIDTH-1:0]  d_rdata,
   input  logic              start_in,
   output logic [WIDTH-1:0]  io_out,
   output logic              fault,
   output logic [WIDTH-1:0]  fault_addr
);

   localparam int S01  = SEG0_SIZE + SEG1_SIZE;
   localparam int S012 = S01 + SEG2_SIZE;
   localparam int IA   = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int A0   = (SEG0_SIZE > 1) ? $clog2(SEG0_SIZE) : 1;
   localparam int A1   = (SEG1_SIZE > 1) ? $clog2(SEG1_SIZE) : 1;
   localparam int A2   = (SEG2_SIZE > 1) ? $clog2(SEG2_SIZE) : 1;
`ifdef IO_TIMER_EN
   localparam int IO_N = (NUM_IO > 3) ? NUM_IO : 3;
`else
   localparam int IO_N = NUM_IO;
`endif

   typedef enum logic [2:0] {SEL_SEG0, SEL_SEG1, SEL_SEG2, SEL_IO, SEL_FAULT} sel_t;

   logic [WIDTH-1:0] seg0_mem [SEG0_SIZE];
   logic [WIDTH-1:0] seg1_mem [SEG1_SIZE];
   logic [WIDTH-1:0] seg2_mem [SEG2_SIZE];

   sel_t             sel;
   logic [A0-1:0]    off0;
   logic [A1-1:0]    off1;
   logic [A2-1:0]    off2;
   logic [1:0]       io_idx;
   logic [IA-1:0]    i_idx;
   logic [WIDTH-1:0] rd_data;
   logic             wr_en;
   logic             io_wr;
   logic             start_s1, start_s2, start_s3, start_latch;
   logic             start_rise;
`ifdef IO_TIMER_EN
   logic [WIDTH-1:0] timer;
`endif

   // First match wins: segments in address order, then the IO window, else fault.
   always_comb begin
      sel = SEL_FAULT;
      if (d_addr < WIDTH'(SEG0_SIZE))
         sel = SEL_SEG0;
      else if (d_addr < WIDTH'(S01))
         sel = SEL_SEG1;
      else if (d_addr < WIDTH'(S012))
         sel = SEL_SEG2;
      else if (d_addr >= WIDTH'(IO_BASE) && d_addr < WIDTH'(IO_BASE + IO_N))
         sel = SEL_IO;
   end

   assign off0       = d_addr[A0-1:0];
   assign off1       = A1'(d_addr - WIDTH'(SEG0_SIZE));
   assign off2       = A2'(d_addr - WIDTH'(S01));
   assign io_idx     = 2'(d_addr - WIDTH'(IO_BASE));
   assign i_idx      = i_addr[IA-1:0];
   assign wr_en      = d_req & d_we;
   assign io_wr      = wr_en & (sel == SEL_IO);
   assign start_rise = start_s2 & ~start_s3;

   always_comb begin
      rd_data = '0;
      case (sel)
         SEL_SEG0: rd_data = seg0_mem[off0];
         SEL_SEG1: rd_data = seg1_mem[off1];
         SEL_SEG2: rd_data = seg2_mem[off2];
         SEL_IO: begin
            case (io_idx)
               2'd0:    rd_data = {{(WIDTH-1){1'b0}}, start_latch};
               2'd1:    rd_data = io_out;
`ifdef IO_TIMER_EN
               // A read sees the count the timer holds after this edge.
               2'd2:    rd_data = timer + WIDTH'(1);
`endif
               default: rd_data = '0;
            endcase
         end
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         case (sel)
            SEL_SEG0: seg0_mem[off0] <= d_wdata;
            SEL_SEG1: seg1_mem[off1] <= d_wdata;
            SEL_SEG2: seg2_mem[off2] <= d_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rvalid    <= 1'b0;
         i_rdata     <= '0;
         i_fault     <= 1'b0;
         d_rvalid    <= 1'b0;
         d_rdata     <= '0;
         io_out      <= '0;
         fault       <= 1'b0;
         fault_addr  <= '0;
         start_s1    <= 1'b0;
         start_s2    <= 1'b0;
         start_s3    <= 1'b0;
         start_latch <= 1'b0;
`ifdef IO_TIMER_EN
         timer       <= '0;
`endif
      end else begin
         i_rvalid <= i_req;
         i_fault  <= i_req && (i_addr >= WIDTH'(IMEM_DEPTH));
         if (i_req)
            i_rdata <= (i_addr < WIDTH'(IMEM_DEPTH)) ? IMEM_INIT[int'(i_idx)*IWIDTH +: IWIDTH] : '0;

         d_rvalid <= d_req & ~d_we;
         if (d_req && !d_we)
            d_rdata <= rd_data;

         if (d_req && sel == SEL_FAULT) begin
            fault <= 1'b1;
            if (!fault)
               fault_addr <= d_addr;
         end

         start_s1 <= start_in;
         start_s2 <= start_s1;
         start_s3 <= start_s2;
         // A set edge outranks a clearing write in the same cycle.
         if (start_rise)
            start_latch <= 1'b1;
         else if (io_wr && io_idx == 2'd0 && d_wdata[0])
            start_latch <= 1'b0;

         if (io_wr && io_idx == 2'd1)
            io_out <= d_wdata;
`ifdef IO_TIMER_EN
         if (io_wr && io_idx == 2'd2)
            timer <= d_wdata;
         else
            timer <= timer + WIDTH'(1);
`endif
      end
   end

endmodule

// File: tb/tb_seg_mem_ctrl.sv
// Directed bench for seg_mem_ctrl: data reads are scored through an expected queue; instruction,
// IO, fault and reset behaviour are checked inline. Honours IO_TIMER_EN like the design.
module tb_seg_mem_ctrl;

   localparam int W    = 32;
   localparam int IW   = 24;
   localparam int IOB  = 1806;
`ifdef IO_TIMER_EN
   localparam int NIO  = 3;
`else
   localparam int NIO  = 2;
`endif
   localparam logic [IW*1024-1:0] ROM = {512{24'hC0FFEE, 24'h123456}};

   logic          clk;
   logic          rst_n;
   logic          i_req;
   logic [W-1:0]  i_addr;
   logic          i_rvalid;
   logic [IW-1:0] i_rdata;
   logic          i_fault;
   logic          d_req;
   logic          d_we;
   logic [W-1:0]  d_addr;
   logic [W-1:0]  d_wdata;
   logic          d_rvalid;
   logic [W-1:0]  d_rdata;
   logic          start_in;
   logic [W-1:0]  io_out;
   logic          fault;
   logic [W-1:0]  fault_addr;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  model [int];
   int            rnd_addr [6];
   int            checks = 0;
   int            errors = 0;

   seg_mem_ctrl #(.IMEM_INIT(ROM)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_fault(i_fault),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .start_in(start_in), .io_out(io_out), .fault(fault), .fault_addr(fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [W-1:0] data);
      d_req = 1'b1; d_we = 1'b1; d_addr = W'(a); d_wdata = data;
      tick();
      d_req = 1'b0; d_we = 1'b0;
      chk("wr_no_rvalid", W'(d_rvalid), W'(0));
   endtask

   task automatic rd(input int a, input logic [W-1:0] exp, input string tag);
      exp_q.push_back(exp);
      d_req = 1'b1; d_we = 1'b0; d_addr = W'(a);
      tick();
      d_req = 1'b0;
      chk({tag, "_rvalid"}, W'(d_rvalid), W'(1));
      chk(tag, d_rdata, exp_q.pop_front());
   endtask

   task automatic ifetch(input int a, input logic [IW-1:0] exp, input logic exp_fault, input string tag);
      i_req = 1'b1; i_addr = W'(a);
      tick();
      i_req = 1'b0;
      chk({tag, "_rvalid"}, W'(i_rvalid), W'(1));
      chk({tag, "_rdata"}, W'(i_rdata), W'(exp));
      chk({tag, "_fault"}, W'(i_fault), W'(exp_fault));
   endtask

   initial begin
      rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; start_in = 1'b0;
      repeat (3) tick();
      chk("rst_i_rvalid", W'(i_rvalid), W'(0));
      chk("rst_i_rdata", W'(i_rdata), W'(0));
      chk("rst_i_fault", W'(i_fault), W'(0));
      chk("rst_d_rvalid", W'(d_rvalid), W'(0));
      chk("rst_d_rdata", d_rdata, W'(0));
      chk("rst_io_out", io_out, W'(0));
      chk("rst_fault", W'(fault), W'(0));
      chk("rst_fault_addr", fault_addr, W'(0));
      rst_n = 1'b1;
      tick();

      // Instruction port
      ifetch(0, 24'h123456, 1'b0, "if_0");
      ifetch(1, 24'hC0FFEE, 1'b0, "if_1");
      ifetch(1023, 24'hC0FFEE, 1'b0, "if_1023");
      tick();
      chk("if_idle_rvalid", W'(i_rvalid), W'(0));
      chk("if_idle_hold", W'(i_rdata), W'(24'hC0FFEE));
      ifetch(1024, 24'h0, 1'b1, "if_1024");
      tick();
      chk("if_fault_pulse", W'(i_fault), W'(0));

      // Segment boundaries
      wr(31, 32'hA5);
      wr(32, 32'hB6);
      wr(1055, 32'h22);
      wr(1056, 32'h33);
      wr(1805, 32'hC7);
      rd(31, 32'hA5, "seg0_last");
      rd(32, 32'hB6, "seg1_first");
      rd(1055, 32'h22, "seg1_last");
      rd(1056, 32'h33, "seg2_first");
      rd(1805, 32'hC7, "seg2_last");
      chk("no_fault_yet", W'(fault), W'(0));

      for (int i = 0; i < 6; i++) begin
         rnd_addr[i] = int'($urandom_range(1100, 1700));
         model[rnd_addr[i]] = $urandom;
         wr(rnd_addr[i], model[rnd_addr[i]]);
      end
      for (int i = 0; i < 6; i++)
         rd(rnd_addr[i], model[rnd_addr[i]], "seg2_rand");

      // Back-to-back write then read
      wr(100, 32'hDEADBEEF);
      rd(100, 32'hDEADBEEF, "wr_then_rd");

      // Fault just past the IO window
      rd(IOB + NIO, 32'h0, "fault_rd");
      chk("fault_set", W'(fault), W'(1));
      chk("fault_addr", fault_addr, W'(IOB + NIO));

      // IO scratch register
      wr(IOB + 1, 32'h5);
      chk("io_out", io_out, W'(5));
      rd(IOB + 1, 32'h5, "io1_rd");

      // Start latch
      rd(IOB, 32'h0, "latch_idle");
      start_in = 1'b1;
      tick();
      tick();
      rd(IOB, 32'h0, "latch_early");
      start_in = 1'b0;
      rd(IOB, 32'h1, "latch_set");
      wr(IOB, 32'h1);
      rd(IOB, 32'h0, "latch_clr");
      repeat (3) tick();
      start_in = 1'b1;
      tick();
      tick();
      wr(IOB, 32'h1);
      start_in = 1'b0;
      rd(IOB, 32'h1, "latch_set_wins");
      wr(IOB, 32'hFFFF_FFFE);
      rd(IOB, 32'h1, "latch_bit0_zero");

      // Timer or its absence
`ifdef IO_TIMER_EN
      wr(IOB + 2, 32'hFFFF_FFFE);
      rd(IOB + 2, 32'hFFFF_FFFF, "timer_0");
      rd(IOB + 2, 32'h0000_0000, "timer_wrap");
`else
      wr(IOB + 2, 32'hFFFF_FFFE);
      chk("timer_absent_fault", W'(fault), W'(1));
      rd(IOB + 2, 32'h0, "timer_absent_rd");
`endif
      wr(5000, 32'h1);
      chk("fault_first_kept", fault_addr, W'(IOB + NIO));
      chk("fault_sticky", W'(fault), W'(1));

      // Asynchronous reset in the middle of a read
      rd(100, 32'hDEADBEEF, "pre_reset_rd");
      d_req = 1'b1; d_we = 1'b0; d_addr = W'(100);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_d_rvalid", W'(d_rvalid), W'(0));
      chk("arst_d_rdata", d_rdata, W'(0));
      chk("arst_fault", W'(fault), W'(0));
      chk("arst_io_out", io_out, W'(0));
      chk("arst_fault_addr", fault_addr, W'(0));
      d_req = 1'b0;
      tick();
      chk("arst_hold_rvalid", W'(d_rvalid), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
